cache_mem_fsm: RTL and testbench
================================

CACHE_MEM_FSM -- requirements
Module: cache_mem_fsm

Interface
REQ-001 Parameter WB_BEATS, default 4: number of writeback beats per dirty block; legal range 1..4.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-low reset; sampled on rising CLK.
REQ-005 dirty  input  1  dirty bit of the cache way currently selected for replacement.
REQ-006 hit  input  1  tag match in the addressed set.
REQ-007 miss  input  1  no tag match; nominally the inverse of hit.
REQ-008 read  input  1  pipeline memory-read request.
REQ-009 write  input  1  pipeline memory-write request.
REQ-010 load  output  1  fill the victim way from the L2 read words and update tag/valid this cycle.
REQ-011 writeback  output  1  writeback of the dirty victim is in progress.
REQ-012 FSM_Write  output  1  L2 write enable, one word per beat.
REQ-013 FSM_Read  output  1  L2 block-read enable.
REQ-014 stall  output  1  freezes the pipeline while high.
REQ-015 set_dirty  output  1  mark the hit way dirty on a write hit.
REQ-016 counter  output  2  writeback word index; selects victim word and address.

Function
REQ-017 The design SHALL be a 4-state FSM: IDLE, WRITEBACK, FETCH, FILL.
REQ-018 "Request" SHALL mean read OR write; write takes precedence when both are high.
REQ-019 "Hit" SHALL take precedence when hit and miss are both high; a miss is decoded as miss=1 and hit=0.
REQ-020 IDLE with no request: all outputs SHALL be 0; state SHALL remain IDLE.
REQ-021 IDLE with a request and a hit: stall=0; set_dirty=1 only if write=1; state SHALL remain IDLE.
REQ-022 IDLE with a request and a miss: stall=1 combinationally in the same cycle.
REQ-023 From that IDLE miss, next state SHALL be WRITEBACK if dirty=1, else FETCH.
REQ-024 WRITEBACK: stall=1, writeback=1, FSM_Write=1; counter SHALL increment once per cycle starting at 0.
REQ-025 WRITEBACK exit: when counter equals WB_BEATS-1, next state SHALL be FETCH and counter SHALL return to 0.
REQ-026 FETCH: stall=1, FSM_Read=1, for exactly 1 cycle; next state SHALL be FILL.
REQ-027 FILL: stall=1, load=1, for exactly 1 cycle; next state SHALL be IDLE.
REQ-028 After FILL, the returning IDLE cycle SHALL re-evaluate the request; it then hits and completes per REQ-021.
REQ-029 Output timing: outputs SHALL be Moore in all states except IDLE; in IDLE, stall and set_dirty SHALL be combinational from the request, hit and miss inputs.
REQ-030 Mutual exclusion: load, FSM_Read and FSM_Write SHALL never be high together.
REQ-031 set_dirty SHALL be 0 in every state except IDLE.
REQ-032 counter SHALL read 0 in every state except WRITEBACK.
REQ-033 Miss latency: a clean miss stalls 3 cycles (IDLE, FETCH, FILL); a dirty miss stalls WB_BEATS+3 cycles.
REQ-034 Request deassertion mid-sequence SHALL NOT abort the sequence; it runs to IDLE.
REQ-035 dirty, read and write SHALL be ignored outside IDLE.

Reset
REQ-036 RST=0 at a rising edge SHALL force state to IDLE and counter to 0 from any state, including mid-WRITEBACK.
REQ-037 While RST=0, all outputs SHALL be driven 0 regardless of inputs.
REQ-038 Reset SHALL take priority over any transition.

Verification
REQ-039 Read hit (read=1, hit=1, miss=0) in IDLE -> stall=0, set_dirty=0, load=0; state stays IDLE.
REQ-040 Write hit (write=1, hit=1) -> same cycle set_dirty=1, stall=0; next cycle, with write=0, set_dirty=0.
REQ-041 Clean read miss (read=1, miss=1, dirty=0) -> stall high for 3 cycles; FSM_Read=1 in cycle 2 only; load=1 in cycle 3 only; IDLE on cycle 4.
REQ-042 Dirty write miss (write=1, miss=1, dirty=1, WB_BEATS=4) -> writeback=FSM_Write=1 for 4 cycles with counter 0,1,2,3; then FETCH, FILL, IDLE; 7 stall cycles total.
REQ-043 RST=0 asserted while counter=2 in WRITEBACK -> next cycle IDLE, counter=0, all outputs 0.
REQ-044 hit=1 and miss=1 with read=1 -> treated as a hit: stall=0, no state change.

Source files
------------

// File: rtl/cache_mem_fsm_if.sv
// Pipeline <-> cache miss controller signal bundle. The pipeline side (master)
// drives the lookup/request inputs; the controller side (slave) drives the sequencing outputs.
interface cache_mem_fsm_if;
  logic       dirty;
  logic       hit;
  logic       miss;
  logic       read;
  logic       write;
  logic       load;
  logic       writeback;
  logic       FSM_Write;
  logic       FSM_Read;
  logic       stall;
  logic       set_dirty;
  logic [1:0] counter;

  modport master (
    output dirty, hit, miss, read, write,
    input  load, writeback, FSM_Write, FSM_Read, stall, set_dirty, counter
  );

  modport slave (
    input  dirty, hit, miss, read, write,
    output load, writeback, FSM_Write, FSM_Read, stall, set_dirty, counter
  );
endinterface

// File: rtl/cache_mem_fsm.sv
// Cache miss controller: IDLE -> [WRITEBACK x WB_BEATS] -> FETCH -> FILL -> IDLE.
// IDLE outputs follow the request/lookup inputs combinationally; other states are Moore.
module cache_mem_fsm #(
  parameter int unsigned WB_BEATS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  cache_mem_fsm_if.slave  bus_if,
  output logic [1:0]      o_state
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FETCH     = 2'd2;
  localparam logic [1:0] ST_FILL      = 2'd3;
  localparam logic [1:0] LAST_BEAT    = 2'(WB_BEATS - 1);

  logic [1:0] r_state;
  logic [1:0] r_counter;
  logic [1:0] w_next_state;
  logic [1:0] w_next_counter;
  logic       w_req;
  logic       w_hit;
  logic       w_miss;

  // Hit wins over miss when both are asserted; write vs read only matters for set_dirty.
  assign w_req  = bus_if.read | bus_if.write;
  assign w_hit  = bus_if.hit;
  assign w_miss = bus_if.miss & ~bus_if.hit;

  always_comb begin
    w_next_state   = r_state;
    w_next_counter = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_miss) begin
          w_next_state = bus_if.dirty ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        if (r_counter == LAST_BEAT) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_counter = r_counter + 2'd1;
        end
      end
      ST_FETCH: w_next_state = ST_FILL;
      ST_FILL:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
    end else begin
      r_state   <= w_next_state;
      r_counter <= w_next_counter;
    end
  end

  // Everything is held low while reset is asserted, whatever state the flops hold.
  always_comb begin
    bus_if.load      = 1'b0;
    bus_if.writeback = 1'b0;
    bus_if.FSM_Write = 1'b0;
    bus_if.FSM_Read  = 1'b0;
    bus_if.stall     = 1'b0;
    bus_if.set_dirty = 1'b0;
    bus_if.counter   = 2'd0;
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE: begin
          bus_if.stall     = w_req & w_miss;
          bus_if.set_dirty = w_req & w_hit & bus_if.write;
        end
        ST_WRITEBACK: begin
          bus_if.stall     = 1'b1;
          bus_if.writeback = 1'b1;
          bus_if.FSM_Write = 1'b1;
          bus_if.counter   = r_counter;
        end
        ST_FETCH: begin
          bus_if.stall    = 1'b1;
          bus_if.FSM_Read = 1'b1;
        end
        ST_FILL: begin
          bus_if.stall = 1'b1;
          bus_if.load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_cache_mem_fsm.sv
// Randomized + directed check of cache_mem_fsm against a miss-schedule reference model.
module tb_cache_mem_fsm;

  localparam int WB_BEATS = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dut_state;
  int         n_checks;
  int         n_fail;
  int         cyc;

  // Expected output vector: {stall, set_dirty, load, writeback, FSM_Write, FSM_Read, counter[1:0]}
  logic [7:0] exp_q[$];
  // Outputs the model has committed to for the cycles after a miss is accepted.
  logic [7:0] sched_q[$];

  cache_mem_fsm_if bus();

  cache_mem_fsm #(.WB_BEATS(WB_BEATS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus_if  (bus.slave),
    .o_state (dut_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n     = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    bus.dirty = 1'b0;
  end

  function automatic logic [7:0] pack(input logic st, input logic sd, input logic ld,
                                      input logic wb, input logic fw, input logic fr,
                                      input logic [1:0] cnt);
    return {st, sd, ld, wb, fw, fr, cnt};
  endfunction

  // Reference model: one call per cycle, given that cycle's inputs.
  task automatic model_cycle(input logic rn, input logic rd, input logic wr,
                             input logic ht, input logic ms, input logic dt);
    logic [7:0] e;
    e = '0;
    if (!rn) begin
      sched_q.delete();
    end else if (sched_q.size() > 0) begin
      e = sched_q.pop_front();
    end else if ((rd || wr) && ht) begin
      e = pack(1'b0, wr, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end else if ((rd || wr) && ms) begin
      e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      if (dt) begin
        for (int b = 0; b < WB_BEATS; b++)
          sched_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'(b)));
      end
      sched_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      sched_q.push_back(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    exp_q.push_back(e);
  endtask

  // Driver: applies one cycle of inputs just after the edge and logs the expectation.
  task automatic drive(input logic rn, input logic rd, input logic wr,
                       input logic ht, input logic ms, input logic dt);
    @(posedge clk);
    #1;
    rst_n     = rn;
    bus.read  = rd;
    bus.write = wr;
    bus.hit   = ht;
    bus.miss  = ms;
    bus.dirty = dt;
    model_cycle(rn, rd, wr, ht, ms, dt);
  endtask

  task automatic drive_junk(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Monitor / scoreboard
  initial begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.stall, bus.set_dirty, bus.load, bus.writeback,
                 bus.FSM_Write, bus.FSM_Read, bus.counter};
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got {st,sd,ld,wb,fw,fr,cnt}=%b required %b",
                   cyc, act_v, exp_v);
        end
        n_checks++;
        if ($countones({bus.load, bus.FSM_Read, bus.FSM_Write}) > 1) begin
          n_fail++;
          $display("FAIL mutex cycle %0d: got load/FSM_Read/FSM_Write=%b%b%b required at most one high",
                   cyc, bus.load, bus.FSM_Read, bus.FSM_Write);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cnt;
    // reset and idle
    repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // read hit
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // write hit then write released
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // read + write with hit: write wins
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    // clean read miss, ignored inputs during FETCH/FILL, then re-evaluated hit
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_junk(2);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // dirty write miss, request dropped mid-sequence
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (WB_BEATS + 2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // hit and miss together: hit wins
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    // reset while counter == 2 in writeback
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_junk(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
